// File: rtl/descrambler_if.sv
// Bus for the descrambler: frame control, serial bit in, descrambled bit and status out.
// service_err is present only when SERVICE_CHECK_EN is defined.
interface descrambler_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             data_in;
    logic             in_valid;
    logic [CNT_W-1:0] data_bits;
    logic [7:0]       tail_pad_length;
    logic             data_out;
    logic             out_valid;
    logic [6:0]       sync_state;
    logic             sync_done;
    logic             frame_done;
    logic             busy;
`ifdef SERVICE_CHECK_EN
    logic             service_err;
`endif

    modport master (
`ifdef SERVICE_CHECK_EN
        input  service_err,
`endif
        output start, data_in, in_valid,
        output data_bits, tail_pad_length,
        input  data_out, out_valid, sync_state,
        input  sync_done, frame_done, busy
    );

    modport slave (
`ifdef SERVICE_CHECK_EN
        output service_err,
`endif
        input  start, data_in, in_valid,
        input  data_bits, tail_pad_length,
        output data_out, out_valid, sync_state,
        output sync_done, frame_done, busy
    );
endinterface

// File: rtl/descrambler.sv
// 802.11a x^7+x^4+1 receive descrambler; LFSR state recovered from SERVICE bits 0..6.
// Optional macro SERVICE_CHECK_EN adds service_err for nonzero descrambled SERVICE bits.
module descrambler #(
    parameter int CNT_W     = 16,
    parameter int TAIL_BITS = 6
) (
    input  logic         Clk,
    input  logic         Reset,
    descrambler_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SYNC, SERVICE, DATA, TAIL, PAD
    } state_t;

    state_t           state_q, state_d, cur;
    logic [CNT_W-1:0] cnt_q, cnt_d, nbits_q, nbits_d;
    logic [7:0]       tp_q, tp_d, tp_eff, tail_len;
    logic [1:7]       s_q, s_d;
    logic [6:0]       sync_state_q, sync_state_d;
    logic             data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_done_q, sync_done_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;
    logic             accept, fb;
    logic [CNT_W-1:0] idx, n_eff, tail_end, last;
`ifdef SERVICE_CHECK_EN
    logic             svc_acc_q, svc_acc_d;
    logic             service_err_q, service_err_d;
`endif

    function automatic state_t phase(
        input logic [CNT_W-1:0] i,
        input logic [CNT_W-1:0] n,
        input logic [CNT_W-1:0] te
    );
        if (i < CNT_W'(7))       return SYNC;
        else if (i < CNT_W'(16)) return SERVICE;
        else if (i < n)          return DATA;
        else if (i < te)         return TAIL;
        else                     return PAD;
    endfunction

    always_comb begin
        fb     = s_q[4] ^ s_q[7];
        accept = bus.in_valid & (busy_q | bus.start);
        // A start cycle is always bit 0 of a fresh frame, even mid-frame.
        cur    = bus.start ? SYNC : state_q;
        idx    = bus.start ? '0 : cnt_q;
        n_eff  = bus.start
               ? ((bus.data_bits < CNT_W'(16)) ? CNT_W'(16) : bus.data_bits)
               : nbits_q;
        tp_eff   = bus.start ? bus.tail_pad_length : tp_q;
        tail_len = (tp_eff < 8'(TAIL_BITS)) ? tp_eff : 8'(TAIL_BITS);
        tail_end = n_eff + CNT_W'(tail_len);
        last     = n_eff + CNT_W'(tp_eff) - CNT_W'(1);

        state_d      = state_q;
        cnt_d        = cnt_q;
        nbits_d      = nbits_q;
        tp_d         = tp_q;
        s_d          = s_q;
        sync_state_d = sync_state_q;
        sync_done_d  = sync_done_q;
        data_out_d   = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
`ifdef SERVICE_CHECK_EN
        svc_acc_d     = svc_acc_q;
        service_err_d = service_err_q;
`endif

        if (bus.start) begin
            state_d     = SYNC;
            cnt_d       = '0;
            nbits_d     = n_eff;
            tp_d        = tp_eff;
            sync_done_d = 1'b0;
`ifdef SERVICE_CHECK_EN
            svc_acc_d     = 1'b0;
            service_err_d = 1'b0;
`endif
        end

        if (accept) begin
            out_valid_d = 1'b1;
            unique case (cur)
                SYNC:    s_d = {bus.data_in, s_q[1:6]};
                TAIL:    s_d = {fb, s_q[1:6]};
                default: begin
                    s_d        = {fb, s_q[1:6]};
                    data_out_d = bus.data_in ^ fb;
                end
            endcase
`ifdef SERVICE_CHECK_EN
            if (cur == SERVICE && data_out_d)
                svc_acc_d = 1'b1;
            if (idx == CNT_W'(15))
                service_err_d = svc_acc_d;
`endif
            if (idx == CNT_W'(6)) begin
                sync_state_d = s_d;
                sync_done_d  = 1'b1;
            end
            if (idx == last) begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
                sync_done_d  = 1'b0;
            end else begin
                cnt_d   = idx + CNT_W'(1);
                state_d = phase(cnt_d, n_eff, tail_end);
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            nbits_q      <= '0;
            tp_q         <= '0;
            s_q          <= '0;
            sync_state_q <= '0;
            data_out_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            sync_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SERVICE_CHECK_EN
            svc_acc_q     <= 1'b0;
            service_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nbits_q      <= nbits_d;
            tp_q         <= tp_d;
            s_q          <= s_d;
            sync_state_q <= sync_state_d;
            data_out_q   <= data_out_d;
            out_valid_q  <= out_valid_d;
            sync_done_q  <= sync_done_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
`ifdef SERVICE_CHECK_EN
            svc_acc_q     <= svc_acc_d;
            service_err_q <= service_err_d;
`endif
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sync_state = sync_state_q;
    assign bus.sync_done  = sync_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
`ifdef SERVICE_CHECK_EN
    assign bus.service_err = service_err_q;
`endif
endmodule

// File: tb/tb_descrambler.sv
// Scoreboard bench for descrambler: driver pushes expected bits, monitor pops on out_valid.
// Service-error checks are compiled in when SERVICE_CHECK_EN is defined.
module tb_descrambler;
    localparam int CNT_W = 16;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    descrambler_if #(.CNT_W(CNT_W)) bus ();

    descrambler #(
        .CNT_W(CNT_W),
        .TAIL_BITS(6)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int asserts = 0;
    int fails = 0;
    int fd_cnt = 0;
    int ov_cnt = 0;
    logic tx_q[$];
    logic ex_q[$];
    logic [1:0] sb_q[$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected {bit, frame_done} per output bit.
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge Clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                ov_cnt++;
                if (bus.frame_done === 1'b1) fd_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("data_out", 32'(bus.data_out), 32'(e[1]));
                    check("frame_done", 32'(bus.frame_done), 32'(e[0]));
                end
            end else if (!Reset && bus.frame_done !== 1'b0) begin
                check("stray_frame_done", 32'(bus.frame_done), 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic st, input logic v, input logic b,
                         input int nb, input int tp);
        @(negedge Clk);
        bus.start           = st;
        bus.in_valid        = v;
        bus.data_in         = b;
        bus.data_bits       = CNT_W'(nb);
        bus.tail_pad_length = 8'(tp);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Scramble a frame with a TX model; expected output is the plaintext
    // with SYNC bits and the first min(6,tp) tail bits forced to zero.
    task automatic build(input logic [6:0] seed, input int nb, input int tp,
                         input int flip, output logic [6:0] st7);
        logic [1:7] s;
        logic p, f, t;
        int tl;
        s = seed;
        st7 = '0;
        tl = (tp < 6) ? tp : 6;
        tx_q.delete();
        ex_q.delete();
        for (int k = 0; k < nb + tp; k++) begin
            p = (k < 16) ? 1'b0 : 1'($urandom_range(1));
            f = s[4] ^ s[7];
            t = p ^ f;
            s = {f, s[1:6]};
            if (k == 6) st7 = s;
            if (k == flip) t = ~t;
            tx_q.push_back(t);
            if (k < 7 || (k >= nb && k < nb + tl))
                ex_q.push_back(1'b0);
            else
                ex_q.push_back((k == flip) ? ~p : p);
        end
    endtask

    task automatic run_frame(input int nb, input int tp,
                             input int stall, input int stop_at);
        int n;
        int lim;
        int i;
        bit first;
        bit v;
        n = tx_q.size();
        lim = (stop_at >= 0) ? stop_at : n;
        i = 0;
        first = 1'b1;
        while (i < lim) begin
            v = ($urandom_range(99) >= stall);
            drive(first, v, v ? tx_q[i] : 1'b0, nb, tp);
            first = 1'b0;
            if (v) begin
                sb_q.push_back({ex_q[i], (i == n - 1)});
                i++;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 50) begin
            @(negedge Clk);
            k++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] lit;
        logic [6:0] st7;

        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in = 1'b0;
        bus.data_bits = '0;
        bus.tail_pad_length = '0;

        repeat (3) @(negedge Clk);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sync_state", 32'(bus.sync_state), 32'd0);
        check("rst_sync_done", 32'(bus.sync_done), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
`ifdef SERVICE_CHECK_EN
        check("rst_service_err", 32'(bus.service_err), 32'd0);
`endif
        Reset = 1'b0;

        // Bits without start are ignored.
        repeat (4) drive(1'b0, 1'b1, 1'b1, 16, 0);
        idle();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Seed 1111111: first 16 scrambled zeros of the 802.11 sequence.
        lit = 16'b0000_1110_1111_0010;
        tx_q.delete();
        ex_q.delete();
        for (int k = 0; k < 16; k++) begin
            tx_q.push_back(lit[15 - k]);
            ex_q.push_back(1'b0);
        end
        fd_cnt = 0;
        run_frame(16, 0, 0, -1);
        check("seed_sync_state", 32'(bus.sync_state), 32'h70);
        check("seed_sync_done", 32'(bus.sync_done), 32'd1);

        // Loopback, started in the frame_done cycle of the seed frame.
        build(7'b1011101, 16 + 8 * 100, 14, -1, st7);
        run_frame(16 + 8 * 100, 14, 0, -1);
        check("loop_sync_state", 32'(bus.sync_state), 32'(st7));
        idle();
        drain();
        check("loop_fd_cnt", 32'(fd_cnt), 32'd2);
        check("loop_busy_end", 32'(bus.busy), 32'd0);
        check("loop_sync_done_end", 32'(bus.sync_done), 32'd0);
`ifdef SERVICE_CHECK_EN
        check("loop_service_err", 32'(bus.service_err), 32'd0);
`endif

        // Same frame with ~40% stalls.
        fd_cnt = 0;
        ov_cnt = 0;
        run_frame(16 + 8 * 100, 14, 40, -1);
        idle();
        drain();
        check("stall_ov_cnt", 32'(ov_cnt), 32'd830);
        check("stall_fd_cnt", 32'(fd_cnt), 32'd1);

        // Abort at bit 300 by a new start.
        fd_cnt = 0;
        build(7'b0100110, 16 + 8 * 100, 14, -1, st7);
        run_frame(16 + 8 * 100, 14, 0, 300);
        check("abort_busy", 32'(bus.busy), 32'd1);
        check("abort_sync_done", 32'(bus.sync_done), 32'd1);
        build(7'b1100011, 16 + 8 * 10, 6, -1, st7);
        run_frame(16 + 8 * 10, 6, 0, -1);
        check("abort2_sync_state", 32'(bus.sync_state), 32'(st7));
        idle();
        drain();
        check("abort_fd_cnt", 32'(fd_cnt), 32'd1);

        // Reset at bit 50.
        fd_cnt = 0;
        build(7'b0011001, 16 + 8 * 100, 14, -1, st7);
        run_frame(16 + 8 * 100, 14, 0, 50);
        @(negedge Clk);
        Reset = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge Clk);
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data_out", 32'(bus.data_out), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_sync_done", 32'(bus.sync_done), 32'd0);
        check("mid_rst_sync_state", 32'(bus.sync_state), 32'd0);
        check("mid_rst_frame_done", 32'(bus.frame_done), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        drain();
        check("mid_rst_fd_cnt", 32'(fd_cnt), 32'd0);

        // Post-reset frame with scrambled SERVICE bit 9 flipped.
        build(7'b1110001, 32, 6, 9, st7);
        run_frame(32, 6, 0, -1);
        idle();
        drain();
        check("post_rst_fd_cnt", 32'(fd_cnt), 32'd1);
`ifdef SERVICE_CHECK_EN
        check("svc_err_set", 32'(bus.service_err), 32'd1);
`endif

        // data_bits < 16 treated as 16; then tail_pad_length < TAIL_BITS.
        fd_cnt = 0;
        build(7'b0000001, 16, 0, -1, st7);
        run_frame(5, 0, 0, -1);
        build(7'b1010101, 40, 3, -1, st7);
        run_frame(40, 3, 20, -1);
        idle();
        drain();
        check("bound_fd_cnt", 32'(fd_cnt), 32'd2);
`ifdef SERVICE_CHECK_EN
        check("svc_err_clear", 32'(bus.service_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end
endmodule
